// File: rtl/pulse_request_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_request_queue_if
//  Brief    : Request-in / grant-out bundle for the pulse request queue.
//  Revision : 1.0 - initial release
// ============================================================================
interface pulse_request_queue_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_CORE = 2,
    parameter int DEPTH    = 8,
    parameter int DROP_W   = 8
);
    localparam int CORE_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic                req_pulse;
    logic [DATA_W-1:0]   req_data;
    logic [NUM_CORE-1:0] core_busy;
    logic                grant_valid;
    logic                grant_ready;
    logic [DATA_W-1:0]   grant_data;
    logic [CORE_W-1:0]   grant_core;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                empty;
    logic [DROP_W-1:0]   drop_cnt;

    modport slave (
        input  req_pulse, req_data, core_busy, grant_ready,
        output grant_valid, grant_data, grant_core, count, full, empty, drop_cnt
    );

    modport master (
        output req_pulse, req_data, core_busy, grant_ready,
        input  grant_valid, grant_data, grant_core, count, full, empty, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pulse_request_queue.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_request_queue
//  Brief    : Show-ahead request FIFO with round-robin idle-core selection
//             and a saturating drop counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_request_queue #(
    parameter int DATA_W   = 8,
    parameter int NUM_CORE = 2,
    parameter int DEPTH    = 8,
    parameter int DROP_W   = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    pulse_request_queue_if.slave   bus
);
    localparam int CORE_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PTR_W  = $clog2(DEPTH);

    localparam logic [CORE_W-1:0] c_last_core = CORE_W'(NUM_CORE - 1);
    localparam logic [CNT_W-1:0]  c_depth     = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CORE_W-1:0] r_rr_ptr;
    logic [DROP_W-1:0] r_drop_cnt;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_found;
    logic              w_grant_valid;
    logic [CORE_W-1:0] w_grant_core;
    logic [CORE_W-1:0] w_scan;
    logic [CORE_W-1:0] w_rr_next;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // Walk the cores starting at the round-robin pointer; first idle one wins.
    always_comb begin
        w_found      = 1'b0;
        w_grant_core = '0;
        w_scan       = r_rr_ptr;
        for (int k = 0; k < NUM_CORE; k++) begin
            if (!w_found && !bus.core_busy[w_scan]) begin
                w_found      = 1'b1;
                w_grant_core = w_scan;
            end
            w_scan = (w_scan == c_last_core) ? '0 : w_scan + CORE_W'(1);
        end
    end

    assign w_grant_valid = !w_empty && w_found;
    assign w_pop         = w_grant_valid && bus.grant_ready;
    // Full is judged on the registered count, so a same-cycle pop never rescues a push.
    assign w_push        = bus.req_pulse && !w_full;
    assign w_drop        = bus.req_pulse && w_full;
    assign w_rr_next     = (w_grant_core == c_last_core) ? '0 : w_grant_core + CORE_W'(1);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.req_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rr_ptr   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_rr_ptr <= w_rr_next;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    assign bus.grant_valid = w_grant_valid;
    assign bus.grant_data  = r_mem[r_rd_ptr];
    assign bus.grant_core  = w_grant_core;
    assign bus.count       = r_count;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.drop_cnt    = r_drop_cnt;
endmodule
`default_nettype wire

// File: tb/tb_pulse_request_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_request_queue
//  Brief    : Queue-model bench for pulse_request_queue with directed and
//             random stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_request_queue;
    localparam int DATA_W   = 8;
    localparam int NUM_CORE = 2;
    localparam int DEPTH    = 8;
    localparam int DROP_W   = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pulse_request_queue_if #(
        .DATA_W(DATA_W), .NUM_CORE(NUM_CORE), .DEPTH(DEPTH), .DROP_W(DROP_W)
    ) bus ();

    pulse_request_queue #(
        .DATA_W(DATA_W), .NUM_CORE(NUM_CORE), .DEPTH(DEPTH), .DROP_W(DROP_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: a plain queue of payloads, a drop tally and a next-core index.
    logic [DATA_W-1:0] mq [$];
    int                m_rr   = 0;
    int                m_drop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_core(input int rr, input logic [NUM_CORE-1:0] busy);
        for (int k = 0; k < NUM_CORE; k++) begin
            int j;
            j = (rr + k) % NUM_CORE;
            if (!busy[j]) return j;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_rr   = 0;
            m_drop = 0;
        end else begin
            bit was_full;
            bit can_grant;
            int c;
            was_full  = (mq.size() == DEPTH);
            can_grant = (mq.size() != 0) && (bus.core_busy != '1);
            c         = exp_core(m_rr, bus.core_busy);
            if (can_grant && bus.grant_ready) begin
                void'(mq.pop_front());
                m_rr = (c + 1) % NUM_CORE;
            end
            if (bus.req_pulse) begin
                if (was_full) begin
                    if (m_drop < DROP_MAX) m_drop++;
                end else begin
                    mq.push_back(bus.req_data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            bit ev;
            ev = (mq.size() != 0) && (bus.core_busy != '1);
            chk("count", 32'(bus.count), mq.size());
            chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
            chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
            chk("drop_cnt", 32'(bus.drop_cnt), m_drop);
            chk("grant_valid", 32'(bus.grant_valid), 32'(ev));
            if (ev) begin
                chk("grant_data", 32'(bus.grant_data), 32'(mq[0]));
                chk("grant_core", 32'(bus.grant_core), exp_core(m_rr, bus.core_busy));
            end
        end
    end

    task automatic drive(input bit p, input logic [DATA_W-1:0] d, input bit r,
                         input logic [NUM_CORE-1:0] b);
        bus.req_pulse   = p;
        bus.req_data    = d;
        bus.grant_ready = r;
        bus.core_busy   = b;
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_valid", 32'(bus.grant_valid), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_drop", 32'(bus.drop_cnt), 0);
        drive(1'b0, '0, 1'b0, '0);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, '0);
        #2;
        do_reset();
        cyc();

        // Dispatch order, alternating cores
        drive(1'b1, 8'h11, 1'b1, 2'b00); @(negedge clk);
        chk("d_valid0", 32'(bus.grant_valid), 1);
        chk("d_data0", 32'(bus.grant_data), 32'h11);
        chk("d_core0", 32'(bus.grant_core), 0);
        #1 drive(1'b1, 8'h22, 1'b1, 2'b00); @(negedge clk);
        chk("d_data1", 32'(bus.grant_data), 32'h22);
        chk("d_core1", 32'(bus.grant_core), 1);
        #1 drive(1'b1, 8'h33, 1'b1, 2'b00); @(negedge clk);
        chk("d_data2", 32'(bus.grant_data), 32'h33);
        chk("d_core2", 32'(bus.grant_core), 0);
        #1 drive(1'b0, '0, 1'b1, 2'b00); @(negedge clk);
        chk("d_empty", 32'(bus.empty), 1);
        #1;

        // Overflow then ordered drain
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 8'(i), 1'b0, 2'b00);
            cyc();
        end
        chk("ov_count", 32'(bus.count), 8);
        chk("ov_full", 32'(bus.full), 1);
        chk("ov_drop", 32'(bus.drop_cnt), 2);
        for (int i = 1; i <= 8; i++) begin
            chk("ov_data", 32'(bus.grant_data), i);
            drive(1'b0, '0, 1'b1, 2'b00);
            cyc();
        end
        chk("ov_empty", 32'(bus.empty), 1);

        // Busy skip and all-busy stall
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0, 2'b01);
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            chk("bs_core", 32'(bus.grant_core), 1);
            drive(1'b0, '0, 1'b1, 2'b01);
            cyc();
        end
        chk("bs_empty", 32'(bus.empty), 1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b0, 2'b11);
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 2'b11);
            cyc();
            chk("ab_valid", 32'(bus.grant_valid), 0);
            chk("ab_count", 32'(bus.count), 2);
        end
        drive(1'b0, '0, 1'b1, 2'b00);
        cyc();
        cyc();

        // Push while full alongside a transfer
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'h50 + i), 1'b0, 2'b00);
            cyc();
        end
        drive(1'b1, 8'hEE, 1'b1, 2'b00);
        cyc();
        chk("pp_count", 32'(bus.count), 7);
        chk("pp_drop", 32'(bus.drop_cnt), 1);
        for (int i = 0; i < 7; i++) begin
            chk("pp_data", 32'(bus.grant_data), 32'h51 + i);
            drive(1'b0, '0, 1'b1, 2'b00);
            cyc();
        end
        chk("pp_empty", 32'(bus.empty), 1);

        // Drop counter saturation, then reset mid-drain
        do_reset();
        for (int i = 0; i < DEPTH + 300; i++) begin
            drive(1'b1, 8'(i), 1'b0, 2'b00);
            cyc();
        end
        chk("sat_drop", 32'(bus.drop_cnt), 255);
        drive(1'b0, '0, 1'b1, 2'b00);
        cyc();
        cyc();
        chk("md_count", 32'(bus.count), 6);
        do_reset();
        cyc();
        chk("md_empty", 32'(bus.empty), 1);
        chk("md_count0", 32'(bus.count), 0);

        // Random traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            drive($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 55,
                  2'($urandom));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
